// File: rtl/mem_slave_if.sv
// Request/response bundle for the word-addressed memory slave.
// The master drives requests; the slave returns one response per accepted request.
interface mem_slave_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  wr_rd;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     data_out;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic                  init_done;

    modport master (
        output req_valid, wr_rd, addr, data, be,
        input  req_ready, data_out, rsp_valid, rsp_err, init_done
    );

    modport slave (
        input  req_valid, wr_rd, addr, data, be,
        output req_ready, data_out, rsp_valid, rsp_err, init_done
    );
endinterface

// File: rtl/mem_slave_pipe.sv
// Word-addressed memory slave with byte enables, optional post-reset clear
// and a fixed-latency in-order response pipeline of RD_LAT stages.
module mem_slave_pipe #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic       clk,
    input  logic       rst,
    mem_slave_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NB    = DATA_W / 8;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   clr_cnt;
    logic               clr_we;
    logic               run;
    logic               accept;
    logic               in_range;
    logic [IDX_W-1:0]   idx;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [RD_LAT-1:0]  pv;
    logic [RD_LAT-1:0]  pe;
    logic [DATA_W-1:0]  pd [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RST != 0) ? S_INIT : S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && clr_cnt == IDX_W'(DEPTH - 1)) begin
            state_nxt = S_RUN;
        end
    end

    // rst gates the visible handshake so the reset cycle itself shows idle outputs
    always_comb begin
        run           = (state == S_RUN) && !rst;
        clr_we        = (state == S_INIT);
        bus.req_ready = run;
        bus.init_done = run;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == S_INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        accept   = bus.req_valid && run;
        in_range = bus.addr < ADDR_W'(DEPTH);
        idx      = bus.addr[IDX_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (accept && bus.wr_rd && in_range) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (bus.be[b]) begin
                    mem[idx][8*b +: 8] <= bus.data[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 samples the word at the accept edge; err/data are zero unless valid
    always_ff @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            pe <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= accept;
            pe[0] <= accept && !in_range;
            pd[0] <= (accept && !bus.wr_rd && in_range) ? mem[idx] : '0;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    always_comb begin
        bus.rsp_valid = pv[RD_LAT-1] && !rst;
        bus.rsp_err   = pe[RD_LAT-1] && !rst;
        bus.data_out  = rst ? '0 : pd[RD_LAT-1];
    end
endmodule

// File: tb/tb_mem_slave_pipe.sv
// Bench for mem_slave_pipe: directed scenarios plus randomized traffic checked
// against an array-based memory model with per-request expected response times.
module tb_mem_slave_pipe;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DEPTH  = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_slave_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_slave_pipe #(
        .DATA_W(32),
        .ADDR_W(32),
        .DEPTH(DEPTH),
        .RD_LAT(RD_LAT),
        .CLEAR_ON_RST(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    int unsigned tests   = 0;
    int unsigned fails   = 0;
    int unsigned cyc     = 0;
    int unsigned dirty   = 0;
    int unsigned rst_cyc = 0;
    rsp_t        act_q[$];
    rsp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: collect every response; count idle cycles with non-zero err/data
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            act_q.push_back('{cyc, bus.rsp_err, bus.data_out});
        end else if (bus.rsp_err !== 1'b0 || bus.data_out !== 32'h0) begin
            dirty++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Presents one request and returns the cycle in which it was accepted.
    // The model computes the response the request must produce RD_LAT cycles later.
    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output int unsigned acc);
        rsp_t e;
        bit   ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.wr_rd     = wr;
        bus.addr      = a;
        bus.data      = d;
        bus.be        = b;
        for (int unsigned k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        acc = cyc;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_ready: req_ready got 0 for 1000 cycles, required 1");
        end else begin
            e.cyc = cyc + RD_LAT;
            if (a < DEPTH) begin
                e.err  = 1'b0;
                e.data = wr ? 32'h0 : model_mem[a];
                if (wr) begin
                    for (int i = 0; i < 4; i++) begin
                        if (b[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
                    end
                end
            end else begin
                e.err  = 1'b1;
                e.data = 32'h0;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int unsigned n);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses rst for one cycle and reports in which post-reset cycle init_done rose.
    task automatic do_reset(output int unsigned n_init, output int unsigned early);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        rst_cyc = cyc;
        @(negedge clk);
        tests++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.init_done} !== 4'b0 ||
            bus.data_out !== 32'h0) begin
            fails++;
            $display("FAIL rst_cycle_outputs: got rdy=%b vld=%b err=%b done=%b data=%h, required all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.init_done, bus.data_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        n_init = 0;
        early  = 0;
        for (int unsigned n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) begin
                tests++;
                if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.init_done} !== 4'b0 ||
                    bus.data_out !== 32'h0) begin
                    fails++;
                    $display("FAIL post_rst_outputs: got rdy=%b vld=%b err=%b done=%b data=%h, required all 0",
                             bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.init_done, bus.data_out);
                end
            end
            if (bus.init_done === 1'b1) begin
                n_init = n;
                break;
            end
            if (bus.req_ready !== 1'b0) early++;
        end
    endtask

    task automatic test_reset();
        int unsigned n_init, early;
        do_reset(n_init, early);
        tests++;
        if (n_init !== 257) begin
            fails++;
            $display("FAIL init_done_cycle: got %0d, required 257", n_init);
        end
        tests++;
        if (early !== 0) begin
            fails++;
            $display("FAIL ready_during_init: got %0d ready cycles, required 0", early);
        end
        tests++;
        if (bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_init: got %b, required 1", bus.req_ready);
        end
    endtask

    task automatic test_clear();
        int unsigned acc;
        int unsigned bad;
        act_q.delete();
        exp_q.delete();
        for (int unsigned a = 0; a < DEPTH; a++) send(1'b0, a, 32'h0, 4'h0, acc);
        idle(RD_LAT + 3);
        tests++;
        if (act_q.size() !== DEPTH) begin
            fails++;
            $display("FAIL clear_count: got %0d responses, required %0d", act_q.size(), DEPTH);
        end
        bad = 0;
        foreach (act_q[i]) if (act_q[i].data !== 32'h0 || act_q[i].err !== 1'b0) bad++;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL clear_data: got %0d nonzero words, required 0", bad);
        end
    endtask

    task automatic test_byte_enable();
        int unsigned a0, a1, a2;
        act_q.delete();
        exp_q.delete();
        send(1'b1, 32'd5, 32'hAABBCCDD, 4'b1111, a0);
        send(1'b1, 32'd5, 32'h11223344, 4'b0101, a1);
        send(1'b0, 32'd5, 32'h0, 4'b0000, a2);
        idle(RD_LAT + 3);
        tests++;
        if (act_q.size() !== 3) begin
            fails++;
            $display("FAIL be_count: got %0d responses, required 3", act_q.size());
        end else begin
            tests++;
            if (act_q[0].data !== 32'h0 || act_q[0].err !== 1'b0 || act_q[0].cyc !== a0 + 2) begin
                fails++;
                $display("FAIL be_write_rsp: got data=%h err=%b cyc=%0d, required 0/0/%0d",
                         act_q[0].data, act_q[0].err, act_q[0].cyc, a0 + 2);
            end
            tests++;
            if (act_q[2].data !== 32'hAA22CC44) begin
                fails++;
                $display("FAIL be_read_data: got %h, required aa22cc44", act_q[2].data);
            end
            tests++;
            if (act_q[2].cyc !== a2 + 2) begin
                fails++;
                $display("FAIL be_read_latency: got cycle %0d, required %0d", act_q[2].cyc, a2 + 2);
            end
        end
    endtask

    task automatic test_out_of_range();
        int unsigned acc;
        logic [32:0] want [5];
        act_q.delete();
        exp_q.delete();
        send(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, acc);
        send(1'b0, 32'h100, 32'h0, 4'h0, acc);
        send(1'b0, 32'h0, 32'h0, 4'h0, acc);
        send(1'b1, 32'h8000_0005, 32'hDEADBEEF, 4'hF, acc);
        send(1'b0, 32'd5, 32'h0, 4'h0, acc);
        idle(RD_LAT + 3);
        want[0] = {1'b1, 32'h0};
        want[1] = {1'b1, 32'h0};
        want[2] = {1'b0, 32'h0};
        want[3] = {1'b1, 32'h0};
        want[4] = {1'b0, 32'hAA22CC44};
        tests++;
        if (act_q.size() !== 5) begin
            fails++;
            $display("FAIL oor_count: got %0d responses, required 5", act_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if ({act_q[i].err, act_q[i].data} !== want[i]) begin
                    fails++;
                    $display("FAIL oor_rsp%0d: got err=%b data=%h, required err=%b data=%h",
                             i, act_q[i].err, act_q[i].data, want[i][32], want[i][31:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned acc, first;
        for (int unsigned a = 0; a < 8; a++) send(1'b1, a, a * 3, 4'hF, acc);
        idle(RD_LAT + 3);
        act_q.delete();
        exp_q.delete();
        for (int unsigned a = 0; a < 8; a++) begin
            send(1'b0, a, 32'h0, 4'h0, acc);
            if (a == 0) first = acc;
        end
        idle(RD_LAT + 3);
        tests++;
        if (act_q.size() !== 8) begin
            fails++;
            $display("FAIL b2b_count: got %0d responses, required 8", act_q.size());
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                tests++;
                if (act_q[i].data !== i * 3 || act_q[i].err !== 1'b0 ||
                    act_q[i].cyc !== first + RD_LAT + i) begin
                    fails++;
                    $display("FAIL b2b_rsp%0d: got data=%0d err=%b cyc=%0d, required %0d/0/%0d",
                             i, act_q[i].data, act_q[i].err, act_q[i].cyc, i * 3, first + RD_LAT + i);
                end
            end
        end
    endtask

    task automatic test_random();
        int unsigned acc, n, bad;
        logic [31:0] a;
        act_q.delete();
        exp_q.delete();
        dirty = 0;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h100;
            else a = $urandom_range(0, 15);
            send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), acc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
        end
        idle(RD_LAT + 3);
        tests++;
        if (act_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL rand_count: got %0d responses, required %0d", act_q.size(), exp_q.size());
        end
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        bad = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if (act_q[i].cyc !== exp_q[i].cyc || act_q[i].err !== exp_q[i].err ||
                act_q[i].data !== exp_q[i].data) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_rsp%0d: got cyc=%0d err=%b data=%h, required cyc=%0d err=%b data=%h",
                             i, act_q[i].cyc, act_q[i].err, act_q[i].data,
                             exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
            end
        end
        tests++;
        if (bad !== 0) fails++;
        tests++;
        if (dirty !== 0) begin
            fails++;
            $display("FAIL idle_outputs: got %0d idle cycles with nonzero err/data, required 0", dirty);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned acc, n_init, early, late;
        send(1'b1, 32'd9, 32'h12345678, 4'hF, acc);
        idle(RD_LAT + 3);
        act_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) send(1'b0, 32'd9, 32'h0, 4'h0, acc);
        do_reset(n_init, early);
        late = 0;
        foreach (act_q[i]) if (act_q[i].cyc >= rst_cyc) late++;
        tests++;
        if (late !== 0) begin
            fails++;
            $display("FAIL mid_rst_flush: got %0d responses after rst, required 0", late);
        end
        tests++;
        if (early !== 0 || n_init !== 257) begin
            fails++;
            $display("FAIL mid_rst_init: got ready_early=%0d init_cycle=%0d, required 0/257", early, n_init);
        end
        act_q.delete();
        exp_q.delete();
        send(1'b0, 32'd9, 32'h0, 4'h0, acc);
        idle(RD_LAT + 3);
        tests++;
        if (act_q.size() !== 1 || act_q[0].data !== 32'h0) begin
            fails++;
            $display("FAIL mid_rst_data: got %0d responses first data=%h, required 1 response data 0",
                     act_q.size(), (act_q.size() > 0) ? act_q[0].data : 32'hX);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.wr_rd     = 1'b0;
        bus.addr      = '0;
        bus.data      = '0;
        bus.be        = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_clear();
        test_byte_enable();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
